// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-port data memory with bounded hold.
// Define DATA_MEM_ARB_ROUND_ROBIN_EN for round-robin tie-break from IDLE.
module data_mem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int HOLD_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     s0_address,
  input  logic [DATA_W/8-1:0]   s0_byteenable,
  input  logic                  s0_read,
  input  logic                  s0_write,
  input  logic [DATA_W-1:0]     s0_writedata,
  output logic                  s0_waitrequest,
  output logic [DATA_W-1:0]     s0_readdata,
  output logic                  s0_readdatavalid,
  input  logic [ADDR_W-1:0]     s1_address,
  input  logic [DATA_W/8-1:0]   s1_byteenable,
  input  logic                  s1_read,
  input  logic                  s1_write,
  input  logic [DATA_W-1:0]     s1_writedata,
  output logic                  s1_waitrequest,
  output logic [DATA_W-1:0]     s1_readdata,
  output logic                  s1_readdatavalid,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX);

  typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             req0, req1;
  logic             gnt0, gnt1;
  logic             held;
  logic             tie0;
  logic             rv0, rv1;

  assign req0 = s0_read | s0_write;
  assign req1 = s1_read | s1_write;
  assign held = (cnt >= CNT_MAX);

`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
  // 1 means port 1 was granted last, so port 0 wins the next tie
  logic last_gnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_gnt <= 1'b1;
    else if (gnt0 | gnt1)
      last_gnt <= gnt1;
  end

  assign tie0 = last_gnt;
`else
  assign tie0 = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= CNT_ONE;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    state_nxt = IDLE;
    cnt_nxt   = CNT_ONE;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          if (req0 && req1) begin
            gnt0 = tie0;
            gnt1 = !tie0;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
        SERVE0: begin
          if (req0 && (!held || !req1))
            gnt0 = 1'b1;
          else
            gnt1 = req1;
        end
        SERVE1: begin
          if (req1 && (!held || !req0))
            gnt1 = 1'b1;
          else
            gnt0 = req0;
        end
        default: ;
      endcase
    end
    if (gnt0) begin
      state_nxt = SERVE0;
      if (state == SERVE0)
        cnt_nxt = held ? cnt : cnt + CNT_ONE;
    end else if (gnt1) begin
      state_nxt = SERVE1;
      if (state == SERVE1)
        cnt_nxt = held ? cnt : cnt + CNT_ONE;
    end
  end

  always_comb begin
    s0_waitrequest = req0 & ~gnt0;
    s1_waitrequest = req1 & ~gnt1;
    mem_clken      = ~reset;
    mem_chipselect = gnt0 | gnt1;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    if (gnt0) begin
      mem_write      = s0_write;
      mem_address    = s0_address;
      mem_byteenable = s0_byteenable;
      mem_writedata  = s0_writedata;
    end else if (gnt1) begin
      mem_write      = s1_write;
      mem_address    = s1_address;
      mem_byteenable = s1_byteenable;
      mem_writedata  = s1_writedata;
    end
  end

  // read+write together is a write, so it never produces a response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rv0 <= 1'b0;
      rv1 <= 1'b0;
    end else begin
      rv0 <= gnt0 & s0_read & ~s0_write;
      rv1 <= gnt1 & s1_read & ~s1_write;
    end
  end

  assign s0_readdatavalid = rv0;
  assign s1_readdatavalid = rv1;
  assign s0_readdata      = mem_readdata;
  assign s1_readdata      = mem_readdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed plus random bench for data_mem_arbiter against a
// transaction-level model of arbitration, memory contents and read responses.
module tb_data_mem_arbiter;

  localparam int HM = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  s0_address, s1_address;
  logic [3:0]  s0_byteenable, s1_byteenable;
  logic        s0_read, s0_write, s1_read, s1_write;
  logic [31:0] s0_writedata, s1_writedata;
  logic        s0_waitrequest, s1_waitrequest;
  logic [31:0] s0_readdata, s1_readdata;
  logic        s0_readdatavalid, s1_readdatavalid;
  logic [9:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_readdata;

  logic        load;
  logic [9:0]  load_addr;
  logic [31:0] load_val;
  logic [31:0] tmem [1024];

  int checks = 0;
  int failures = 0;

  int          prev, run_len, last_srv;
  bit          pv0, pv1;
  logic [31:0] pdata;
  logic [31:0] rmem [1024];

  data_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .HOLD_MAX(HM)) dut (
    .clk(clk), .reset(reset),
    .s0_address(s0_address), .s0_byteenable(s0_byteenable),
    .s0_read(s0_read), .s0_write(s0_write),
    .s0_writedata(s0_writedata), .s0_waitrequest(s0_waitrequest),
    .s0_readdata(s0_readdata), .s0_readdatavalid(s0_readdatavalid),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable),
    .s1_read(s1_read), .s1_write(s1_write),
    .s1_writedata(s1_writedata), .s1_waitrequest(s1_waitrequest),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  // single-port synchronous memory, read data one cycle after address
  always @(posedge clk) begin
    if (load)
      tmem[load_addr] <= load_val;
    else if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b])
            tmem[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end else
        mem_readdata <= tmem[mem_address];
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    prev = -1;
    run_len = 0;
    last_srv = 1;
    pv0 = 1'b0;
    pv1 = 1'b0;
  endtask

  // -1 none, else port number granted this cycle
  function automatic int ref_grant(input bit r0, input bit r1);
    if (r0 && r1) begin
      if (prev < 0) begin
`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
        return (last_srv == 0) ? 1 : 0;
`else
        return 0;
`endif
      end
      return (run_len < HM) ? prev : 1 - prev;
    end
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic idle();
    s0_read = 0; s0_write = 0; s1_read = 0; s1_write = 0;
    s0_address = '0; s1_address = '0;
    s0_byteenable = '0; s1_byteenable = '0;
    s0_writedata = '0; s1_writedata = '0;
  endtask

  task automatic set0(input bit rd, input bit wr, input logic [9:0] a,
                      input logic [3:0] be, input logic [31:0] d);
    s0_read = rd; s0_write = wr; s0_address = a;
    s0_byteenable = be; s0_writedata = d;
  endtask

  task automatic set1(input bit rd, input bit wr, input logic [9:0] a,
                      input logic [3:0] be, input logic [31:0] d);
    s1_read = rd; s1_write = wr; s1_address = a;
    s1_byteenable = be; s1_writedata = d;
  endtask

  // one clock: check request-side outputs, then the response after the edge
  task automatic cyc(input bit rst_hit = 1'b0);
    int          g;
    bit          wr, rd;
    logic [9:0]  ad;
    logic [3:0]  be;
    logic [31:0] wd;
    @(negedge clk);
    g = ref_grant(s0_read | s0_write, s1_read | s1_write);
    chk1("wait0", s0_waitrequest, (s0_read | s0_write) && g != 0);
    chk1("wait1", s1_waitrequest, (s1_read | s1_write) && g != 1);
    chk1("chipselect", mem_chipselect, g >= 0);
    wr = (g == 0) ? s0_write : (g == 1) ? s1_write : 1'b0;
    rd = !wr && ((g == 0) ? s0_read : (g == 1) ? s1_read : 1'b0);
    ad = (g == 1) ? s1_address : s0_address;
    be = (g == 1) ? s1_byteenable : s0_byteenable;
    wd = (g == 1) ? s1_writedata : s0_writedata;
    chk1("mem_write", mem_write, wr);
    if (g >= 0) chk32("mem_address", {22'd0, mem_address}, {22'd0, ad});
    if (wr) begin
      chk32("mem_wdata", mem_writedata, wd);
      chk32("mem_be", {28'd0, mem_byteenable}, {28'd0, be});
    end
    @(posedge clk);
    if (rst_hit) reset = 1'b1;
    #1;
    pv0 = 1'b0;
    pv1 = 1'b0;
    if (g >= 0) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) rmem[ad][b*8 +: 8] = wd[b*8 +: 8];
      end
      if (rd) begin
        if (g == 0) pv0 = 1'b1; else pv1 = 1'b1;
        pdata = rmem[ad];
      end
      run_len = (prev == g) ? run_len + 1 : 1;
      prev = g;
      last_srv = g;
    end else begin
      prev = -1;
      run_len = 0;
    end
    if (rst_hit) model_reset();
    chk1("rdvalid0", s0_readdatavalid, pv0);
    chk1("rdvalid1", s1_readdatavalid, pv1);
    if (pv0) chk32("rdata0", s0_readdata, pdata);
    if (pv1) chk32("rdata1", s1_readdata, pdata);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    s0_read = 1'b1;
    s1_read = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk1("rst_wait0", s0_waitrequest, 1'b1);
      chk1("rst_wait1", s1_waitrequest, 1'b1);
      chk1("rst_cs", mem_chipselect, 1'b0);
      chk1("rst_mwr", mem_write, 1'b0);
      chk1("rst_clken", mem_clken, 1'b0);
      chk1("rst_rdv0", s0_readdatavalid, 1'b0);
      chk1("rst_rdv1", s1_readdatavalid, 1'b0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    idle();
    model_reset();
  endtask

  initial begin
    reset = 1'b1;
    load = 1'b0;
    load_addr = '0;
    load_val = '0;
    idle();
    model_reset();
    for (int i = 0; i < 33; i++) begin
      load = 1'b1;
      load_addr = (i == 32) ? 10'h3FF : 10'(i);
      load_val = $urandom;
      rmem[load_addr] = load_val;
      @(posedge clk);
      #1;
    end
    load = 1'b0;
    do_reset();

    // first tie after reset, then runs of HM grants while both read
    set0(1, 0, 10'h001, 4'hF, 0);
    set1(1, 0, 10'h002, 4'hF, 0);
    for (int i = 0; i < 16; i++) begin
      #1;
      chk1("run_wait0", s0_waitrequest, ((i / 4) % 2) == 1);
      chk1("run_wait1", s1_waitrequest, ((i / 4) % 2) == 0);
      cyc();
    end

    // second tie from IDLE after port 0 was last served
    idle(); cyc();
    set0(1, 0, 10'h003, 4'hF, 0); cyc();
    idle(); cyc();
    set0(1, 0, 10'h003, 4'hF, 0);
    set1(1, 0, 10'h004, 4'hF, 0);
    #1;
`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
    chk1("tie2_wait0", s0_waitrequest, 1'b1);
`else
    chk1("tie2_wait0", s0_waitrequest, 1'b0);
`endif
    cyc();
    idle(); cyc();

    set0(0, 1, 10'h005, 4'hF, 32'hDEADBEEF); cyc();
    set0(1, 0, 10'h005, 4'hF, 0); cyc();
    chk1("wr_rd_valid", s0_readdatavalid, 1'b1);
    chk32("wr_rd_data", s0_readdata, 32'hDEADBEEF);
    idle();

    set1(0, 1, 10'h3FF, 4'hF, 32'hFFFFFFFF); cyc();
    set1(0, 1, 10'h3FF, 4'h3, 32'h12345678); cyc();
    set1(1, 0, 10'h3FF, 4'hF, 0); cyc();
    chk1("be_valid", s1_readdatavalid, 1'b1);
    chk32("be_data", s1_readdata, 32'hFFFF5678);
    idle();

    set0(1, 1, 10'h010, 4'hF, 32'hA5A5A5A5); cyc();
    chk1("rw_no_valid", s0_readdatavalid, 1'b0);
    set0(1, 0, 10'h010, 4'hF, 0); cyc();
    chk32("rw_data", s0_readdata, 32'hA5A5A5A5);
    idle(); cyc();

    // reset lands on the edge that would deliver the response
    set0(1, 0, 10'h005, 4'hF, 0); cyc(1'b1);
    idle();
    chk1("rst_mid_cs", mem_chipselect, 1'b0);
    chk1("rst_mid_clken", mem_clken, 1'b0);
    @(posedge clk);
    #1;
    chk1("rst_mid_rdv0", s0_readdatavalid, 1'b0);
    reset = 1'b0;
    set0(1, 0, 10'h005, 4'hF, 0);
    set1(1, 0, 10'h002, 4'hF, 0);
    #1;
    chk1("post_rst_wait0", s0_waitrequest, 1'b0);
    cyc();
    chk32("post_rst_data", s0_readdata, 32'hDEADBEEF);
    idle(); cyc();

    for (int i = 0; i < 400; i++) begin
      set0($urandom_range(0, 2) != 0 ? 1'b1 : 1'b0, $urandom_range(0, 3) == 0,
           10'($urandom_range(0, 31)), 4'($urandom), $urandom);
      set1($urandom_range(0, 2) != 0 ? 1'b1 : 1'b0, $urandom_range(0, 3) == 0,
           10'($urandom_range(0, 31)), 4'($urandom), $urandom);
      if ($urandom_range(0, 5) == 0) idle();
      cyc();
    end

    idle(); cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10: word-address width of the shared single-port data memory (1024 words).
REQ-002 Parameter DATA_W, default 32: data width; byteenable width is DATA_W/8.
REQ-003 Parameter HOLD_MAX, default 4: maximum number of consecutive grants to one port while the other port is requesting.
REQ-004 One clock; reset is asynchronous and active-high; ports named clk and reset.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 sN_address (N=0,1)  input  ADDR_W  requester word address.
REQ-008 sN_byteenable  input  DATA_W/8  requester write byte lanes.
REQ-009 sN_read  input  1  read request.
REQ-010 sN_write  input  1  write request.
REQ-011 sN_writedata  input  DATA_W  write data.
REQ-012 sN_waitrequest  output  1  request not accepted this cycle.
REQ-013 sN_readdata  output  DATA_W  read data, qualified by sN_readdatavalid.
REQ-014 sN_readdatavalid  output  1  sN_readdata valid this cycle.
REQ-015 mem_address / mem_byteenable / mem_writedata  output  ADDR_W / DATA_W/8 / DATA_W  to memory.
REQ-016 mem_chipselect, mem_write, mem_clken  output  1 each  memory controls.
REQ-017 mem_readdata  input  DATA_W  memory output, valid one cycle after address issue.

Function
REQ-018 reqN = sN_read | sN_write; a request is accepted in a cycle iff it is granted and sN_waitrequest is 0 in that cycle.
REQ-019 The FSM shall have states IDLE, SERVE0, SERVE1 and a hold counter cnt (range 1..HOLD_MAX, saturating).
REQ-020 IDLE: single request granted; both requesting -> arbitration per REQ-033/REQ-034.
REQ-021 SERVEk: grant k if reqk and (cnt < HOLD_MAX or other not requesting); else grant other if requesting; else no grant.
REQ-022 Next state = SERVEg on grant to g, IDLE on no grant; cnt increments on repeat grant to same port, loads 1 on change of port.
REQ-023 sN_waitrequest = reqN & ~grantN, combinational from current state, cnt and requests; 0 when not requesting.
REQ-024 On grant g: mem_chipselect=1, mem_address/byteenable/writedata from port g, mem_write=sg_write; no grant: mem_chipselect=0, mem_write=0.
REQ-025 mem_clken shall be 1 whenever reset is deasserted.
REQ-026 Accepted read by port g in cycle T: sg_readdatavalid=1 in cycle T+1 with sg_readdata=mem_readdata; one read per cycle, back-to-back fully pipelined.
REQ-027 sN_readdata shall equal mem_readdata at all times; only readdatavalid is per-port.
REQ-028 sN_read and sN_write both high: treated as a write; no readdatavalid produced.
REQ-029 Write followed by read of same address next cycle shall return the written data (memory single-port ordering preserved; no reordering).

Reset
REQ-030 While reset is asserted: state IDLE, cnt=1, sN_readdatavalid=0, sN_waitrequest=reqN, mem_chipselect=0, mem_write=0, mem_clken=0.
REQ-031 Reset asserted mid-operation shall discard any pending readdatavalid; no response is delivered for reads accepted in the cycle reset rises.
REQ-032 First grant is possible in the first clock edge after reset deasserts.

Configuration
REQ-033 Macro DATA_MEM_ARB_ROUND_ROBIN_EN defined: IDLE tie-break grants the port not granted last (last-grant register, reset value 1 so port 0 wins first).
REQ-034 Macro undefined: IDLE tie-break always grants port 0; HOLD_MAX rule in SERVEk still applies.

Verification
REQ-035 s0 write addr 0x005 data 0xDEADBEEF be 0xF, then s0 read 0x005 -> s0_readdatavalid one cycle after read accept, readdata 0xDEADBEEF.
REQ-036 s0 and s1 both read continuously, HOLD_MAX=4 -> grants alternate in runs of 4, each waitrequest high for exactly 4 cycles per run.
REQ-037 Both request from IDLE after reset -> port 0 granted; with ROUND_ROBIN_EN second IDLE tie goes to port 1, without it to port 0.
REQ-038 s1 write 0x3FF be 0x3 data 0x12345678 over prior 0xFFFFFFFF, then read -> 0xFFFF5678.
REQ-039 Reset asserted the cycle after s0 read accept -> no s0_readdatavalid; state IDLE; next request granted first cycle after reset release.
REQ-040 s0 read and write both high, addr 0x010 data 0xA5A5A5A5 -> memory written, no readdatavalid; subsequent read returns 0xA5A5A5A5.
